// File: rtl/uart_pkg.sv
// Register offsets, CON bit positions and the shared TX/RX state encoding for the bus UART.
package uart_pkg;

   localparam logic [7:0] UART_TXD_OFS = 8'h18;
   localparam logic [7:0] UART_RXD_OFS = 8'h1C;
   localparam logic [7:0] UART_CON_OFS = 8'h20;

   localparam int CON_TX_IE   = 0;
   localparam int CON_RX_IE   = 1;
   localparam int CON_RX_DONE = 2;
   localparam int CON_TX_DONE = 3;
   localparam int CON_TX_BUSY = 4;
   localparam int CON_OVR     = 5;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_bus_responder_if.sv
// CPU data-bus slice seen by the UART: qualified strobes, address, store data and load data.
// Single-cycle transactions with no wait states, so there is no backpressure path.
interface uart_bus_responder_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, wr, addr, wdata, input rdata);
   modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser behind a 2-flop synchroniser; mid-bit sampling, glitch reject, framing-error hold.
// byte_vld pulses for one clock at a good stop sample; there is no backpressure.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_dat,
   output logic       byte_vld
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   uart_state_t   state;
   logic [1:0]    sync;
   logic          rx_s;
   logic          rx_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          wait_hi;

   assign rx_s     = sync[1];
   assign byte_dat = shreg;
   assign byte_vld = (state == STOP) && !wait_hi && (cnt == BIT_END) && rx_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         wait_hi <= 1'b0;
      end else begin
         sync    <= {sync[0], rx};
         rx_prev <= rx_s;
         case (state)
            IDLE: if (rx_prev && !rx_s) begin
               state <= START;
               cnt   <= '0;
            end
            START: if (cnt == HALF_END) begin
               cnt     <= '0;
               bit_idx <= 3'd0;
               state   <= rx_s ? IDLE : DATA;
            end else begin
               cnt <= cnt + CW'(1);
            end
            DATA: if (cnt == BIT_END) begin
               cnt   <= '0;
               shreg <= {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) begin
                  bit_idx <= 3'd0;
                  state   <= STOP;
               end else begin
                  bit_idx <= bit_idx + 3'd1;
               end
            end else begin
               cnt <= cnt + CW'(1);
            end
            STOP: if (wait_hi) begin
               // framing error: stay out of IDLE until the line has recovered
               if (rx_s) begin
                  wait_hi <= 1'b0;
                  state   <= IDLE;
               end
            end else if (cnt == BIT_END) begin
               cnt <= '0;
               if (rx_s) state <= IDLE;
               else      wait_hi <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: start bit is driven on the clock after start, each bit lasts CLKS_PER_BIT clocks.
// start is ignored while a frame is in flight, except on the final clock of the stop bit.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);
   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (cnt == BIT_END);
   assign busy    = (state != IDLE);
   // done marks the last stop-bit clock so the flag lands on the same edge the FSM goes idle
   assign done    = (state == STOP) && bit_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         if (state != IDLE) begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
         end
         case (state)
            START: if (bit_end) begin
               state <= DATA;
               tx    <= shreg[0];
            end
            DATA: if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  state   <= STOP;
                  bit_idx <= 3'd0;
                  tx      <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  shreg   <= {1'b0, shreg[7:1]};
                  tx      <= shreg[1];
               end
            end
            STOP: if (bit_end) begin
               state <= IDLE;
            end
            default: ;
         endcase
         if (start && ((state == IDLE) || done)) begin
            state <= START;
            shreg <= data;
            cnt   <= '0;
            tx    <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART: TXD/RXD/CON decode, sticky flags and irq; loads are combinational, stores land at posedge.
// No wait states; a TXD store while the transmitter is busy is dropped.
module uart_bus_responder
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 9600
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_bus_responder_if.slave   bus,
   output logic                  irq,
   input  logic                  rx,
   output logic                  tx
);
   localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

   logic [7:0]  ofs;
   logic        txd_wr;
   logic        con_wr;
   logic        con_rd;
   logic        tx_busy;
   logic        tx_fin;
   logic        rx_vld;
   logic [7:0]  rx_dat;
   logic        tx_ie;
   logic        rx_ie;
   logic        tx_done;
   logic        rx_done;
   logic        ovr;
   logic [7:0]  rx_byte;
   logic [31:0] con_val;
   logic        unused_bits;

   assign ofs         = bus.addr[7:0];
   assign txd_wr      = bus.wr && (ofs == UART_TXD_OFS);
   assign con_wr      = bus.wr && (ofs == UART_CON_OFS);
   assign con_rd      = bus.rd && (ofs == UART_CON_OFS);
   assign unused_bits = &{1'b0, bus.addr[31:8], bus.wdata[31:8]};

   uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk   (clk),
      .reset (reset),
      .start (txd_wr),
      .data  (bus.wdata[7:0]),
      .tx    (tx),
      .busy  (tx_busy),
      .done  (tx_fin)
   );

   uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .byte_dat (rx_dat),
      .byte_vld (rx_vld)
   );

   // a flag event outranks a CON-read clear in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_ie   <= 1'b0;
         rx_ie   <= 1'b0;
         tx_done <= 1'b0;
         rx_done <= 1'b0;
         ovr     <= 1'b0;
         rx_byte <= 8'h00;
      end else begin
         if (con_wr) begin
            tx_ie <= bus.wdata[0];
            rx_ie <= bus.wdata[1];
         end
         if (tx_fin)      tx_done <= 1'b1;
         else if (con_rd) tx_done <= 1'b0;
         if (rx_vld)      rx_done <= 1'b1;
         else if (con_rd) rx_done <= 1'b0;
         if (rx_vld && rx_done) ovr <= 1'b1;
         else if (con_rd)       ovr <= 1'b0;
         if (rx_vld) rx_byte <= rx_dat;
      end
   end

   always_comb begin
      con_val              = '0;
      con_val[CON_TX_IE]   = tx_ie;
      con_val[CON_RX_IE]   = rx_ie;
      con_val[CON_RX_DONE] = rx_done;
      con_val[CON_TX_DONE] = tx_done;
      con_val[CON_TX_BUSY] = tx_busy;
      con_val[CON_OVR]     = ovr;
      bus.rdata            = '0;
      if (bus.rd) begin
         case (ofs)
            UART_RXD_OFS: bus.rdata = {24'd0, rx_byte};
            UART_CON_OFS: bus.rdata = con_val;
            default:      bus.rdata = '0;
         endcase
      end
   end

   assign irq = (tx_ie & tx_done) | (rx_ie & rx_done);

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder at 10 clk/bit: scripted register-map scenarios then randomized TX/RX traffic.
module tb_uart_bus_responder;
   localparam logic [7:0] TXD = 8'h18;
   localparam logic [7:0] RXD = 8'h1C;
   localparam logic [7:0] CON = 8'h20;
   localparam int         BIT_CLKS = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic rx = 1'b1;
   logic tx;
   logic irq;

   uart_bus_responder_if bus();

   uart_bus_responder #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq),
      .rx    (rx),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [31:0] rdq[$];
   logic [7:0]  txq[$];
   bit win = 1'b0;

   // behavioural view of the register file, updated from the events the bench causes
   bit m_txie, m_rxie, m_txdone, m_rxdone, m_ovr, m_busy;
   logic [7:0] m_rxbyte;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] con_exp();
      return {26'd0, m_ovr, m_busy, m_txdone, m_rxdone, m_rxie, m_txie};
   endfunction

   function automatic logic irq_exp();
      return (m_txie & m_txdone) | (m_rxie & m_rxdone);
   endfunction

   function automatic logic exp_tx_bit(input logic [7:0] d, input int i);
      int k;
      k = i / BIT_CLKS;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return d[k-1];
   endfunction

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.addr  = {2'b01, 22'($urandom), a};
      bus.wdata = d;
      bus.wr    = 1'b1;
      @(posedge clk); #1;
      bus.wr    = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, input logic [31:0] exp);
      @(posedge clk); #1;
      rdq.push_back(exp);
      bus.addr = {2'b01, 22'($urandom), a};
      bus.rd   = 1'b1;
      @(posedge clk); #1;
      bus.rd   = 1'b0;
   endtask

   task automatic rd_con();
      bus_read(CON, con_exp());
      m_txdone = 1'b0;
      m_rxdone = 1'b0;
      m_ovr    = 1'b0;
   endtask

   task automatic wr_con(input bit txie, input bit rxie);
      bus_write(CON, {$urandom, 2'b00} | {30'd0, rxie, txie});
      m_txie = txie;
      m_rxie = rxie;
   endtask

   task automatic chk_irq(input string name);
      @(negedge clk);
      check(name, {31'd0, irq}, {31'd0, irq_exp()});
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx = fr[i];
         repeat (BIT_CLKS - 1) @(negedge clk);
      end
      @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic rx_model(input logic [7:0] b, input logic stop);
      if (stop) begin
         if (m_rxdone) m_ovr = 1'b1;
         m_rxdone = 1'b1;
         m_rxbyte = b;
      end
   endtask

   task automatic send_tx(input logic [7:0] b);
      txq.push_back(b);
      bus_write(TXD, {$urandom, b} & 32'hFFFF_FFFF);
   endtask

   // bus-read scoreboard: every single-cycle read pops its expected value
   always @(negedge clk) begin
      if (bus.rd === 1'b1 && !win) begin
         if (rdq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rdata_unexpected: got %h expected no read", bus.rdata);
         end else begin
            check("rdata", bus.rdata, rdq.pop_front());
         end
      end
   end

   // serial-line monitor: captures 100 clocks of each frame and compares to the ideal waveform
   initial begin : tx_mon
      logic [7:0] e;
      logic [7:0] got;
      int errs;
      bit aborted;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && tx === 1'b0) begin
            errs    = 0;
            aborted = 1'b0;
            got     = 8'h00;
            e       = (txq.size() == 0) ? 8'h00 : txq[0];
            for (int i = 1; i < 10 * BIT_CLKS; i++) begin
               @(negedge clk);
               if (reset !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (tx !== exp_tx_bit(e, i)) errs++;
               if ((i % BIT_CLKS) == BIT_CLKS / 2 && i / BIT_CLKS >= 1 && i / BIT_CLKS <= 8)
                  got[i / BIT_CLKS - 1] = tx;
            end
            if (!aborted) begin
               if (txq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL tx_unexpected_frame: got byte %h expected no frame", got);
               end else begin
                  e = txq.pop_front();
                  check("tx_byte", {24'd0, got}, {24'd0, e});
                  check("tx_waveform_errs", errs, 0);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin : main
      logic [7:0] b;
      logic [7:0] b2;
      bit stp;
      bit seen;
      int mode;
      bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
      {m_txie, m_rxie, m_txdone, m_rxdone, m_ovr, m_busy} = '0;
      m_rxbyte = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      check("tx_in_reset", {31'd0, tx}, 32'd1);
      check("irq_in_reset", {31'd0, irq}, 32'd0);
      reset = 1'b1;

      // reset mid-frame
      bus_write(TXD, 32'h0000_0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("tx_start_bit", {31'd0, tx}, 32'd0);
      #2 reset = 1'b0;
      #1 check("tx_async_reset", {31'd0, tx}, 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rd_con();
      bus_read(RXD, 32'd0);
      chk_irq("irq_after_reset");
      @(negedge clk);
      bus.addr = {24'd0, CON};
      #1 check("rdata_no_rd", bus.rdata, 32'd0);

      // single frame, busy visible throughout, dropped second write
      wr_con(1'b1, 1'b0);
      send_tx(8'hA5);
      m_busy = 1'b1;
      bus_read(CON, con_exp());
      repeat (40) @(posedge clk);
      bus_write(TXD, 32'h0000_003C);
      repeat (54) @(posedge clk);
      bus_read(CON, con_exp());
      m_busy = 1'b0;
      m_txdone = 1'b1;
      chk_irq("irq_tx_done");
      rd_con();
      chk_irq("irq_tx_cleared");

      // TXD write on the stop-exit clock is accepted
      b = 8'($urandom); b2 = 8'($urandom);
      send_tx(b);
      repeat (98) @(posedge clk);
      send_tx(b2);
      repeat (105) @(posedge clk);
      m_txdone = 1'b1;
      chk_irq("irq_b2b");
      rd_con();

      // unmapped accesses
      bus_write(8'h10, 32'hFFFF_FFFF);
      bus_read(8'h24, 32'd0);
      rd_con();

      // receive with rx_ie
      wr_con(1'b0, 1'b1);
      drive_rx(8'h5A, 1'b1);
      repeat (3) @(posedge clk);
      rx_model(8'h5A, 1'b1);
      chk_irq("irq_rx_done");
      bus_read(RXD, 32'h0000_005A);
      rd_con();
      chk_irq("irq_rx_cleared");

      // overrun
      wr_con(1'b0, 1'b0);
      drive_rx(8'h11, 1'b1);
      drive_rx(8'h22, 1'b1);
      repeat (3) @(posedge clk);
      rx_model(8'h11, 1'b1);
      rx_model(8'h22, 1'b1);
      bus_read(RXD, 32'h0000_0022);
      rd_con();
      rd_con();

      // glitch and framing error leave state alone
      @(negedge clk); rx = 1'b0;
      repeat (3) @(negedge clk); rx = 1'b1;
      repeat (20) @(negedge clk);
      drive_rx(8'h77, 1'b0);
      repeat (5) @(posedge clk);
      bus_read(RXD, {24'd0, m_rxbyte});
      rd_con();

      // CON read held across the rx_done set edge
      b = 8'($urandom);
      seen = 1'b0;
      fork
         drive_rx(b, 1'b1);
         begin
            repeat (85) @(negedge clk);
            win = 1'b1;
            bus.addr = {24'd0, CON};
            bus.rd = 1'b1;
            for (int i = 0; i < 30; i++) begin
               @(negedge clk);
               seen = seen | bus.rdata[2];
            end
            bus.rd = 1'b0;
            win = 1'b0;
         end
      join
      check("rx_done_set_beats_clear", {31'd0, seen}, 32'd1);
      m_rxbyte = b; m_rxdone = 1'b0; m_ovr = 1'b0; m_txdone = 1'b0;
      bus_read(RXD, {24'd0, m_rxbyte});
      rd_con();

      // randomized traffic against the model
      for (int it = 0; it < 8; it++) begin
         mode = $urandom_range(0, 2);
         b    = 8'($urandom);
         b2   = 8'($urandom);
         stp  = ($urandom_range(0, 3) != 0);
         wr_con(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         case (mode)
            0: begin
               send_tx(b);
               repeat (102) @(posedge clk);
               m_txdone = 1'b1;
            end
            1: begin
               drive_rx(b2, stp);
               repeat (3) @(posedge clk);
               rx_model(b2, stp);
            end
            default: begin
               fork
                  send_tx(b);
                  drive_rx(b2, stp);
               join
               repeat (5) @(posedge clk);
               m_txdone = 1'b1;
               rx_model(b2, stp);
            end
         endcase
         repeat (2) @(posedge clk);
         chk_irq("irq_rand");
         bus_read(RXD, {24'd0, m_rxbyte});
         if ($urandom_range(0, 1) == 1) rd_con();
      end
      rd_con();

      repeat (20) @(posedge clk);
      check("tx_frames_pending", txq.size(), 0);
      check("reads_pending", rdq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
